// File: rtl/div_seq.sv
// div_seq: multi-cycle sequencer for MIPS DIV/DIVU.
//
// Runs a 32-iteration radix-2 restoring division on operand magnitudes and
// applies the sign correction when the last iteration completes. The result
// is held in END until the execute stage drops start_i.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend, sampled on the accept cycle only
//   opdata2_i     divisor, sampled on the accept cycle only
//   start_i       request, held until the result is consumed
//   annul_i       cancel the in-flight operation
//   result_o      {remainder, quotient}, zero unless ready_o
//   ready_o       registered result-valid
//   stallreq_o    combinational pipeline stall request
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        StFree,
        StByZero,
        StOn,
        StEnd
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        sdiv_q, sdiv_d;
    logic        neg1_q, neg1_d;
    logic        neg2_q, neg2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] op1_abs, op2_abs;
    logic [33:0] rem_sh;
    logic [33:0] trial;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes; unsigned operands pass through untouched.
    always_comb begin
        op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // One restoring step. The partial remainder stays below the divisor, so
    // carrying an extra top bit only keeps every register bit in the datapath.
    always_comb begin
        rem_sh   = {rem_q, quo_q[31]};
        trial    = rem_sh - {2'b00, dvsr_q};
        rem_step = trial[33] ? rem_sh[32:0] : trial[32:0];
        quo_step = {quo_q[30:0], ~trial[33]};
        quo_fix  = (sdiv_q && (neg1_q ^ neg2_q)) ? (~quo_step + 32'd1) : quo_step;
        rem_fix  = (sdiv_q && neg1_q) ? (~rem_step[31:0] + 32'd1) : rem_step[31:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        sdiv_d   = sdiv_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            StFree: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    sdiv_d = signed_div_i;
                    neg1_d = signed_div_i & opdata1_i[31];
                    neg2_d = signed_div_i & opdata2_i[31];
                    if (opdata2_i == 32'd0) begin
                        state_d = StByZero;
                    end else begin
                        state_d = StOn;
                        cnt_d   = 6'd0;
                        rem_d   = 33'd0;
                        quo_d   = op1_abs;
                        dvsr_d  = op2_abs;
                    end
                end
            end

            StByZero: begin
                if (annul_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    state_d  = StEnd;
                    ready_d  = 1'b1;
                    result_d = 64'd0;
                end
            end

            StOn: begin
                if (annul_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = StEnd;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end

            StEnd: begin
                // Annul wins over a still-asserted start.
                if (annul_i || !start_i) begin
                    state_d  = StFree;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end

            default: begin
                state_d  = StFree;
                ready_d  = 1'b0;
                result_d = 64'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFree;
            cnt_q    <= 6'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            sdiv_q   <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            sdiv_q   <= sdiv_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~annul_i & (state_q != StEnd);

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the MIPS DIV/DIVU instructions. It is started by the execute stage, runs a 32-iteration radix-2 restoring division, and stalls the pipeline while busy. It returns {remainder, quotient} for the HI/LO write path. It owns no HI/LO state itself: the execute stage forwards `result_o[63:32]` to HI and `result_o[31:0]` to LO on the cycle `ready_o` is high.

## Interface
Parameters: none (fixed 32-bit operands, 64-bit result).
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend, sampled only on the accept cycle
- opdata2_i  in  32  divisor, sampled only on the accept cycle
- start_i  in  1  request; held high by the execute stage until it has consumed the result
- annul_i  in  1  cancel the in-flight operation (branch/exception flush)
- result_o  out  64  {remainder, quotient}; valid only while ready_o = 1, else 0
- ready_o  out  1  registered; result valid
- stallreq_o  out  1  combinational pipeline stall request

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result held.
- Internal registers:
  - state.
  - 6-bit counter cnt.
  - 33-bit partial remainder R.
  - 32-bit quotient Q.
  - |divisor| D.
  - Latched signed_div, dividend sign and divisor sign.
- FREE:
  - If start_i = 1, annul_i = 0 and opdata2_i = 0: go to BYZERO.
  - If start_i = 1, annul_i = 0 and opdata2_i ≠ 0: go to ON with cnt = 0, R = 0, Q = |opdata1_i|, D = |opdata2_i|.
  - Magnitude is two's-complement negation when signed_div_i = 1 and bit 31 = 1; otherwise the operand is taken unchanged.
  - Otherwise stay in FREE.
- ON, each cycle:
  - Shift {R,Q} left by 1.
  - T = R_shifted − {1'b0,D}, 33-bit.
  - If T[32] = 0: R = T and Q[0] = 1. Otherwise R is left shifted and Q[0] = 0.
  - cnt += 1.
  - When cnt reaches 31 (the 32nd iteration), go to END and latch the signed correction into the result register:
    - Quotient is negated if signed and dividend sign ≠ divisor sign.
    - Remainder is negated if signed and dividend is negative.
- BYZERO: one cycle, then go to END with result = 0.
- END:
  - ready_o = 1 and result_o = result register.
  - Stay in END while start_i = 1.
  - When start_i = 0, go to FREE. ready_o and result_o clear on the same edge.
- annul_i = 1 in BYZERO, ON or END: go to FREE next edge, with ready_o = 0 and result_o = 0. annul_i in FREE is ignored and no operation is accepted.
- stallreq_o = start_i & ~annul_i & (state ≠ END). This stalls on the accept cycle and through BYZERO/ON, and releases in END.
- Special case −2^31 ÷ −1 (signed): quotient = 0x80000000, remainder = 0 (wraps; architecturally undefined). No trap.
- Unsigned operands are never negated.

## Timing
- Reset: state = FREE, cnt = 0, R = Q = D = 0, result_o = 0, ready_o = 0. stallreq_o follows its equation (0 unless start_i).
- Latency, accept edge = cycle 0:
  - Nonzero divisor: ON during cycles 1–32, ready_o = 1 from cycle 33.
  - Zero divisor: BYZERO in cycle 1, ready_o = 1 from cycle 2.
- Back-to-back operations: start_i must drop for at least one cycle (END → FREE) before a new operation is accepted. Minimum issue interval is 35 cycles for a nonzero divisor.
- rst mid-operation overrides everything, including annul_i and start_i, and returns all state to reset values on that edge.
- Operand changes after the accept cycle have no effect.
- annul_i together with start_i in END: annul wins.

## Test plan
- DIVU 100 / 7, start held: stallreq_o = 1 for cycles 0–32. ready_o rises at cycle 33 with result_o = {0x00000002, 0x0000000E}. Dropping start_i clears ready_o next edge.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2: {0x00000001, 0xFFFFFFFD}. DIVU 0xFFFFFFFF / 1: {0, 0xFFFFFFFF}.
- Divisor 0 (DIV 5 / 0): ready_o = 1 at cycle 2 with result_o = 0, and stallreq_o falls at cycle 2.
- annul_i pulsed at cycle 10 of an ON sequence: state FREE at cycle 11, ready_o never asserts, stallreq_o = 0. A new start at cycle 12 completes normally at cycle 45.
- rst asserted at cycle 20 mid-ON: all outputs 0 next edge. A following DIVU 0x80000000 / 0x10 gives {0, 0x08000000} at 33-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF: result_o = {0x00000000, 0x80000000}, with no hang and no error.
